// File: rtl/ascon_params.sv
// Shared Ascon constants, state encoding and round-constant helper.
// Holds PAR, NSLICE, MAX_ROUNDS, the scheduler state_t enum and rc().
package ascon_params;

  localparam int PAR = 1;
  localparam int NSLICE = (64 + PAR - 1) / PAR;
  localparam int NUMBER_BIT_MASK = NSLICE + 1;
  localparam int MAX_ROUNDS = 12;
  localparam int SW = $clog2(NSLICE);

  typedef enum logic [2:0] {
    IDLE,
    CONST,
    SBOX,
    FLUSH,
    LINEAR,
    DONE
  } state_t;

  // p^nr uses the last nr of the twelve p^12 constants
  function automatic logic [7:0] rc(
    input logic [3:0] nr,
    input logic [3:0] round
  );
    logic [3:0] i;
    i = 4'(MAX_ROUNDS) - nr + round;
    return {4'hF - i, i};
  endfunction

endpackage

// File: rtl/ascon_perm_sched_if.sv
// Scheduler bus: mode-FSM start/done, randomness handshake, datapath strobes.
// master = mode FSM / LFSR bank / datapath side, slave = scheduler.
// Optional stall_cnt_o present when ASCON_PERM_STALL_CNT_EN is defined.
interface ascon_perm_sched_if;
  import ascon_params::*;

  logic          start_i;
  logic [3:0]    rounds_i;
  logic          busy_o;
  logic          done_o;
  logic          rnd_valid_i;
  logic          rnd_ready_o;
  logic          add_const_o;
  logic [7:0]    round_const_o;
  logic          slice_en_o;
  logic [SW-1:0] slice_idx_o;
  logic          flush_o;
  logic          linear_en_o;
  logic [3:0]    round_o;
`ifdef ASCON_PERM_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  modport master (
    output start_i, rounds_i, rnd_valid_i,
    input  busy_o, done_o, rnd_ready_o,
    input  add_const_o, round_const_o,
    input  slice_en_o, slice_idx_o,
    input  flush_o, linear_en_o, round_o
`ifdef ASCON_PERM_STALL_CNT_EN
    , input stall_cnt_o
`endif
  );

  modport slave (
    input  start_i, rounds_i, rnd_valid_i,
    output busy_o, done_o, rnd_ready_o,
    output add_const_o, round_const_o,
    output slice_en_o, slice_idx_o,
    output flush_o, linear_en_o, round_o
`ifdef ASCON_PERM_STALL_CNT_EN
    , output stall_cnt_o
`endif
  );

endinterface

// File: rtl/ascon_perm_sched.sv
// Round/slice scheduler for the masked bit-serial Ascon permutation.
// Ports: clk, rst_n (async low), bus (ascon_perm_sched_if.slave).
// Round: CONST, NSLICE randomness-gated SBOX slices, FLUSH, LINEAR.
// Macro ASCON_PERM_STALL_CNT_EN adds a saturating SBOX stall counter.
module ascon_perm_sched
  import ascon_params::*;
(
  input logic               clk,
  input logic               rst_n,
  ascon_perm_sched_if.slave bus
);

  state_t        state, nxt_state;
  logic [3:0]    nr, nxt_nr;
  logic [3:0]    round, nxt_round;
  logic [SW-1:0] slice, nxt_slice;
  logic          xfer;
  logic [3:0]    rounds_sat;

  assign xfer = (state == SBOX) & bus.rnd_valid_i;

  assign rounds_sat =
    (bus.rounds_i == 4'd0 || bus.rounds_i > 4'(MAX_ROUNDS))
      ? 4'(MAX_ROUNDS) : bus.rounds_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      nr    <= '0;
      round <= '0;
      slice <= '0;
    end else begin
      state <= nxt_state;
      nr    <= nxt_nr;
      round <= nxt_round;
      slice <= nxt_slice;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_nr    = nr;
    nxt_round = round;
    nxt_slice = slice;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          nxt_nr    = rounds_sat;
          nxt_round = '0;
          nxt_state = CONST;
        end
      end
      CONST: begin
        nxt_slice = '0;
        nxt_state = SBOX;
      end
      SBOX: begin
        if (xfer) begin
          nxt_slice = slice + SW'(1);
          if (slice == SW'(NSLICE - 1))
            nxt_state = FLUSH;
        end
      end
      FLUSH: nxt_state = LINEAR;
      LINEAR: begin
        if (round == nr - 4'd1) begin
          nxt_state = DONE;
        end else begin
          nxt_round = round + 4'd1;
          nxt_state = CONST;
        end
      end
      DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign bus.busy_o        = (state != IDLE);
  assign bus.done_o        = (state == DONE);
  assign bus.rnd_ready_o   = (state == SBOX);
  assign bus.add_const_o   = (state == CONST);
  assign bus.round_const_o =
    (state == CONST) ? rc(nr, round) : 8'h00;
  assign bus.slice_en_o    = xfer;
  assign bus.slice_idx_o   = slice;
  assign bus.flush_o       = (state == FLUSH);
  assign bus.linear_en_o   = (state == LINEAR);
  assign bus.round_o       = round;

`ifdef ASCON_PERM_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == IDLE && bus.start_i)
      stall_cnt <= '0;
    else if (state == SBOX && !bus.rnd_valid_i
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed self-checking bench for ascon_perm_sched.
// Covers reset, p^12, stalled p^6, round saturation, back-to-back, abort.
`timescale 1ns/1ps
module tb_ascon_perm_sched;
  import ascon_params::*;

  logic clk;
  logic rst_n;

  ascon_perm_sched_if bus ();

  ascon_perm_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         done_q[$];
  logic [7:0] const_q[$];
  int         n_slice, n_flush, n_lin, n_excl;
  bit         busy_after, aborted;

  logic [7:0] rc12 [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  logic [24:0] outs;
  assign outs = {
    bus.busy_o, bus.done_o, bus.rnd_ready_o,
    bus.add_const_o, bus.round_const_o,
    bus.slice_en_o, bus.slice_idx_o,
    bus.flush_o, bus.linear_en_o, bus.round_o
  };

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(
    input logic [3:0] r,
    input bit         hold,
    input int         st_round,
    input int         st_len,
    input bit         abort,
    input int         limit
  );
    int stall_left;
    int nstb;
    done_q.delete();
    const_q.delete();
    n_slice = 0;
    n_flush = 0;
    n_lin = 0;
    n_excl = 0;
    busy_after = 1'b1;
    aborted = 1'b0;
    stall_left = st_len;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.rounds_i = r;
    bus.rnd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start_i = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      bus.rnd_valid_i = 1'b1;
      if (abort && bus.rnd_ready_o
          && bus.round_o == 4'd4
          && bus.slice_idx_o == SW'(10)) begin
        rst_n = 1'b0;
        #1;
        chk("abort_zero", 32'(outs), 32'd0);
        aborted = 1'b1;
        break;
      end
      if (stall_left > 0 && bus.rnd_ready_o
          && int'(bus.round_o) == st_round
          && bus.slice_idx_o == SW'(5)) begin
        bus.rnd_valid_i = 1'b0;
        stall_left--;
      end
      #1;
      nstb = int'(bus.add_const_o) + int'(bus.slice_en_o)
           + int'(bus.flush_o) + int'(bus.linear_en_o)
           + int'(bus.done_o);
      if (nstb > 1) n_excl++;
      if (bus.add_const_o) const_q.push_back(bus.round_const_o);
      if (bus.slice_en_o) n_slice++;
      if (bus.flush_o) n_flush++;
      if (bus.linear_en_o) n_lin++;
      if (bus.done_o) done_q.push_back(n);
      if (!hold && done_q.size() > 0 && n == done_q[0] + 1) begin
        busy_after = bus.busy_o;
        break;
      end
    end
  endtask

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.rounds_i = 4'd0;
    bus.rnd_valid_i = 1'b0;

    // reset / idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rnd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_outs", 32'(outs), 32'd0);
    end
`ifdef ASCON_PERM_STALL_CNT_EN
    chk("idle_stall", 32'(bus.stall_cnt_o), 32'd0);
`endif

    // p^12, no stalls
    run(4'd12, 1'b0, 0, 0, 1'b0, 900);
    chk("p12_done", 32'(first_done()), 32'd805);
    chk("p12_ndone", 32'(done_q.size()), 32'd1);
    chk("p12_nconst", 32'(const_q.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk("p12_rc",
          (i < const_q.size()) ? 32'(const_q[i]) : 32'hFFFF,
          32'(rc12[i]));
    chk("p12_slices", 32'(n_slice), 32'd768);
    chk("p12_flush", 32'(n_flush), 32'd12);
    chk("p12_linear", 32'(n_lin), 32'd12);
    chk("p12_excl", 32'(n_excl), 32'd0);
    chk("p12_busy_drop", 32'(busy_after), 32'd0);
`ifdef ASCON_PERM_STALL_CNT_EN
    chk("p12_stall", 32'(bus.stall_cnt_o), 32'd0);
`endif

    // p^6 with a 10-cycle stall at round 2 slice 5
    run(4'd6, 1'b0, 2, 10, 1'b0, 500);
    chk("p6_done", 32'(first_done()), 32'd413);
    chk("p6_nconst", 32'(const_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("p6_rc",
          (i < const_q.size()) ? 32'(const_q[i]) : 32'hFFFF,
          32'(rc12[6 + i]));
    chk("p6_slices", 32'(n_slice), 32'd384);
    chk("p6_excl", 32'(n_excl), 32'd0);
`ifdef ASCON_PERM_STALL_CNT_EN
    chk("p6_stall", 32'(bus.stall_cnt_o), 32'd10);
    repeat (3) @(negedge clk);
    chk("p6_stall_hold", 32'(bus.stall_cnt_o), 32'd10);
`endif

    // out-of-range round counts saturate to 12
    run(4'd0, 1'b0, 0, 0, 1'b0, 900);
    chk("r0_done", 32'(first_done()), 32'd805);
    chk("r0_first_rc",
        (const_q.size() > 0) ? 32'(const_q[0]) : 32'hFFFF,
        32'h0F0);
    run(4'd15, 1'b0, 0, 0, 1'b0, 900);
    chk("r15_done", 32'(first_done()), 32'd805);
    chk("r15_nconst", 32'(const_q.size()), 32'd12);

    // start held high: back-to-back, no double starts
    run(4'd12, 1'b1, 0, 0, 1'b0, 1612);
    bus.start_i = 1'b0;
    chk("b2b_ndone", 32'(done_q.size()), 32'd2);
    chk("b2b_done0", 32'(first_done()), 32'd805);
    chk("b2b_done1",
        (done_q.size() > 1) ? 32'(done_q[1]) : 32'hFFFF,
        32'd1611);
    chk("b2b_nconst", 32'(const_q.size()), 32'd24);
    chk("b2b_excl", 32'(n_excl), 32'd0);
    do_reset();

    // reset during SBOX of round 4
    run(4'd12, 1'b0, 0, 0, 1'b1, 900);
    chk("abort_hit", 32'(aborted), 32'd1);
    chk("abort_ndone", 32'(done_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_hold", 32'(outs), 32'd0);
    rst_n = 1'b1;
    run(4'd12, 1'b0, 0, 0, 1'b0, 900);
    chk("post_abort_done", 32'(first_done()), 32'd805);
    chk("post_abort_nconst", 32'(const_q.size()), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
